mofn_code_checker: RTL and testbench

MOFN_CODE_CHECKER -- requirements
Module: mofn_code_checker

---
 rtl/mofn_code_checker.sv | 124 ++++++++++++
 tb/tb_mofn_code_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mofn_code_checker.sv
// M-of-N code word checker: one-cycle DET/ERR verdict, saturating statistics
// and a NORMAL/WARN/ALARM supervisor driven by runs of invalid words.
module mofn_code_checker #(
  parameter int unsigned N       = 5,
  parameter int unsigned M       = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ERR_LIM = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_code_valid,
  input  logic [N-1:0]     i_code,
  input  logic             i_clr_stats,
  input  logic             i_clr_alarm,
  output logic             o_det_valid,
  output logic             o_det,
  output logic             o_err,
  output logic [CNT_W-1:0] o_total_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_warn,
  output logic             o_alarm
);

  localparam int unsigned PC_W  = $clog2(N + 1);
  localparam int unsigned RUN_W = 8;

  // State bits double as the registered WARN/ALARM outputs.
  localparam logic [1:0] S_NORMAL = 2'b00;
  localparam logic [1:0] S_WARN   = 2'b01;
  localparam logic [1:0] S_ALARM  = 2'b10;

  logic [1:0]       r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_det_valid;
  logic             r_det;
  logic             r_err;
  logic [CNT_W-1:0] r_total_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [PC_W-1:0]  w_ones;
  logic             w_match;
  logic             w_acc_err;
  logic [1:0]       w_state_base;
  logic [1:0]       w_state_nxt;
  logic [RUN_W-1:0] w_run_base;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_total_nxt;
  logic [CNT_W-1:0] w_err_nxt;

  always_comb begin
    w_ones = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_ones = w_ones + PC_W'(i_code[i]);
    end
  end

  assign w_match   = (w_ones == PC_W'(M));
  assign w_acc_err = i_code_valid & ~w_match;

  // Alarm clear is applied before the coincident word is evaluated.
  always_comb begin
    w_run_base   = i_clr_alarm ? '0 : r_run;
    w_state_base = i_clr_alarm ? S_NORMAL : r_state;
    w_run_inc    = (w_run_base == '1) ? w_run_base : w_run_base + RUN_W'(1);
    w_run_nxt    = w_run_base;
    w_state_nxt  = w_state_base;
    if (i_code_valid) begin
      if (w_match) begin
        w_run_nxt   = '0;
        w_state_nxt = (w_state_base == S_ALARM) ? S_ALARM : S_NORMAL;
      end else begin
        w_run_nxt = w_run_inc;
        if (w_run_inc >= RUN_W'(ERR_LIM)) begin
          w_state_nxt = S_ALARM;
        end else if (w_state_base != S_ALARM) begin
          w_state_nxt = S_WARN;
        end
      end
    end
  end

  // Clear wins over the update but still keeps this cycle's increment.
  always_comb begin
    w_total_nxt = r_total_cnt;
    w_err_nxt   = r_err_cnt;
    if (i_clr_stats) begin
      w_total_nxt = CNT_W'(i_code_valid);
      w_err_nxt   = CNT_W'(w_acc_err);
    end else begin
      if (i_code_valid && (r_total_cnt != '1)) w_total_nxt = r_total_cnt + CNT_W'(1);
      if (w_acc_err && (r_err_cnt != '1))      w_err_nxt   = r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_NORMAL;
      r_run       <= '0;
      r_det_valid <= 1'b0;
      r_det       <= 1'b0;
      r_err       <= 1'b0;
      r_total_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_det_valid <= i_code_valid;
      r_det       <= i_code_valid & w_match;
      r_err       <= w_acc_err;
      r_total_cnt <= w_total_nxt;
      r_err_cnt   <= w_err_nxt;
    end
  end

  assign o_det_valid = r_det_valid;
  assign o_det       = r_det;
  assign o_err       = r_err;
  assign o_total_cnt = r_total_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_warn      = r_state[0];
  assign o_alarm     = r_state[1];

endmodule

// File: tb/tb_mofn_code_checker.sv
// Self-checking bench: four checker builds against a behavioural model of the
// population-count, statistics and alarm-supervisor rules.
module tb_mofn_code_checker;

  logic       clk = 1'b0;
  logic       rst_n, v, cs, ca;
  logic [4:0] code;
  logic [7:0] code8;

  logic       d0_dv, d0_det, d0_err, d0_warn, d0_alarm;
  logic [7:0] d0_tot, d0_ecnt;
  logic       d1_dv, d1_det, d1_err, d1_warn, d1_alarm;
  logic [1:0] d1_tot, d1_ecnt;
  logic       z_dv, z_det, z_err, z_warn, z_alarm;
  logic [7:0] z_tot, z_ecnt;
  logic       o_dv, o_det, o_err, o_warn, o_alarm;
  logic [7:0] o_tot, o_ecnt;

  int nchk = 0;
  int nerr = 0;

  // Model state for the two N=5/M=2 builds: index 0 = (CNT_W 8, LIM 3), 1 = (CNT_W 2, LIM 1).
  int m_tot[2], m_ecnt[2], m_run[2];
  bit m_alarm[2], m_warn[2];
  int lim[2]  = '{3, 1};
  int cmax[2] = '{255, 3};
  bit e_dv, e_det, e_err, e_z, e_o;

  always #5 clk = ~clk;

  mofn_code_checker #(.N(5), .M(2), .CNT_W(8), .ERR_LIM(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(v), .i_code(code),
    .i_clr_stats(cs), .i_clr_alarm(ca), .o_det_valid(d0_dv), .o_det(d0_det),
    .o_err(d0_err), .o_total_cnt(d0_tot), .o_err_cnt(d0_ecnt),
    .o_warn(d0_warn), .o_alarm(d0_alarm));

  mofn_code_checker #(.N(5), .M(2), .CNT_W(2), .ERR_LIM(1)) dut_lim1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(v), .i_code(code),
    .i_clr_stats(cs), .i_clr_alarm(ca), .o_det_valid(d1_dv), .o_det(d1_det),
    .o_err(d1_err), .o_total_cnt(d1_tot), .o_err_cnt(d1_ecnt),
    .o_warn(d1_warn), .o_alarm(d1_alarm));

  mofn_code_checker #(.N(8), .M(0), .CNT_W(8), .ERR_LIM(3)) dut_m0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(v), .i_code(code8),
    .i_clr_stats(cs), .i_clr_alarm(ca), .o_det_valid(z_dv), .o_det(z_det),
    .o_err(z_err), .o_total_cnt(z_tot), .o_err_cnt(z_ecnt),
    .o_warn(z_warn), .o_alarm(z_alarm));

  mofn_code_checker #(.N(8), .M(8), .CNT_W(8), .ERR_LIM(3)) dut_m8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(v), .i_code(code8),
    .i_clr_stats(cs), .i_clr_alarm(ca), .o_det_valid(o_dv), .o_det(o_det),
    .o_err(o_err), .o_total_cnt(o_tot), .o_err_cnt(o_ecnt),
    .o_warn(o_warn), .o_alarm(o_alarm));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ok;
    ok = v && ($countones(code) == 2);
    e_dv  = rst_n && v;
    e_det = rst_n && v && ok;
    e_err = rst_n && v && !ok;
    e_z   = rst_n && v && (code8 == 8'h00);
    e_o   = rst_n && v && (code8 == 8'hFF);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_tot[k] = 0; m_ecnt[k] = 0; m_run[k] = 0; m_alarm[k] = 0;
      end else begin
        if (cs) begin
          m_tot[k]  = v ? 1 : 0;
          m_ecnt[k] = e_err ? 1 : 0;
        end else begin
          if (v)     m_tot[k]  = (m_tot[k]  + 1 > cmax[k]) ? cmax[k] : m_tot[k] + 1;
          if (e_err) m_ecnt[k] = (m_ecnt[k] + 1 > cmax[k]) ? cmax[k] : m_ecnt[k] + 1;
        end
        if (ca) begin
          m_alarm[k] = 0; m_run[k] = 0;
        end
        if (v) begin
          if (ok) m_run[k] = 0;
          else begin
            m_run[k] = (m_run[k] == 255) ? 255 : m_run[k] + 1;
            if (m_run[k] >= lim[k]) m_alarm[k] = 1;
          end
        end
      end
      m_warn[k] = !m_alarm[k] && (m_run[k] > 0);
    end
  endtask

  task automatic cyc(input logic r, input logic vv, input logic [4:0] c,
                     input logic s, input logic a, input logic [7:0] c8);
    rst_n = r; v = vv; code = c; cs = s; ca = a; code8 = c8;
    @(posedge clk);
    model_step();
    #1;
    chk("d0_dv", d0_dv, e_dv);   chk("d0_det", d0_det, e_det); chk("d0_err", d0_err, e_err);
    chk("d0_tot", d0_tot, m_tot[0]); chk("d0_ecnt", d0_ecnt, m_ecnt[0]);
    chk("d0_warn", d0_warn, m_warn[0]); chk("d0_alarm", d0_alarm, m_alarm[0]);
    chk("d1_dv", d1_dv, e_dv);   chk("d1_det", d1_det, e_det); chk("d1_err", d1_err, e_err);
    chk("d1_tot", d1_tot, m_tot[1]); chk("d1_ecnt", d1_ecnt, m_ecnt[1]);
    chk("d1_warn", d1_warn, m_warn[1]); chk("d1_alarm", d1_alarm, m_alarm[1]);
    chk("m0_dv", z_dv, e_dv); chk("m0_det", z_det, e_z); chk("m0_err", z_err, e_dv && !e_z);
    chk("m8_dv", o_dv, e_dv); chk("m8_det", o_det, e_o); chk("m8_err", o_err, e_dv && !e_o);
  endtask

  task automatic word(input logic [4:0] c);
    cyc(1'b1, 1'b1, c, 1'b0, 1'b0, 8'h5A);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'bx, 1'b0, 1'b0, 8'bx);
  endtask

  initial begin
    int ndet, nerrp;
    logic [7:0] base;

    // Reset with words presented: they must be discarded.
    cyc(1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 8'hFF);
    chk("rst_tot", d0_tot, 0);
    idle(); idle();

    // Exhaustive sweep of all 32 words back-to-back.
    ndet = 0; nerrp = 0;
    for (int i = 0; i < 32; i++) begin
      word(5'(i));
      if (d0_det) ndet++;
      if (d0_err) nerrp++;
    end
    chk("ex_det_pulses", ndet, 10);
    chk("ex_err_pulses", nerrp, 22);
    chk("ex_total", d0_tot, 32);
    chk("ex_errcnt", d0_ecnt, 22);
    idle();

    // Clear everything, then walk the WARN / ALARM sequence.
    cyc(1'b1, 1'b0, 5'bx, 1'b1, 1'b1, 8'bx);
    word(5'b00000); chk("seq_warn1", d0_warn, 1);
    word(5'b11111); chk("seq_warn2", d0_warn, 1);
    word(5'b00011); chk("seq_norm", d0_warn, 0);
    for (int i = 0; i < 3; i++) word(5'b00000);
    chk("seq_alarm", d0_alarm, 1);
    for (int i = 0; i < 4; i++) word(5'b00011);
    chk("seq_sticky", d0_alarm, 1);

    // Alarm clear coincident with a valid word.
    cyc(1'b1, 1'b1, 5'b10001, 1'b0, 1'b1, 8'h00);
    chk("clr_valid_alarm", d0_alarm, 0); chk("clr_valid_det", d0_det, 1);
    // Re-arm, then clear coincident with an invalid word.
    for (int i = 0; i < 3; i++) word(5'b11100 ^ 5'b00001);
    cyc(1'b1, 1'b1, 5'b11111, 1'b0, 1'b1, 8'hFF);
    chk("clr_inv_warn", d0_warn, 1); chk("clr_inv_lim1", d1_alarm, 1);

    // Saturation of the 2-bit build and clear-vs-increment priority.
    cyc(1'b1, 1'b0, 5'bx, 1'b1, 1'b1, 8'bx);
    for (int i = 0; i < 5; i++) word(5'b00111);
    chk("sat_ecnt", d1_ecnt, 3);
    cyc(1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h01);
    chk("clr_ecnt", d1_ecnt, 1); chk("clr_tot", d1_tot, 1);

    // Mid-stream reset with a valid word in the reset cycle.
    word(5'b00011); word(5'b01111);
    cyc(1'b0, 1'b1, 5'b00101, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_dv", d0_dv, 0);
    word(5'b11111);
    chk("restart_tot", d0_tot, 1); chk("restart_err", d0_err, 1);

    // M=0 / M=8 builds: exact words and every single-bit flip.
    for (int i = 0; i < 9; i++) begin
      base = (i == 8) ? 8'h00 : (8'h01 << i);
      cyc(1'b1, 1'b1, 5'b00011, 1'b0, 1'b0, base);
      cyc(1'b1, 1'b1, 5'b00011, 1'b0, 1'b0, ~base);
    end

    // Random traffic including undriven code while idle.
    for (int i = 0; i < 400; i++) begin
      logic       rv;
      logic [4:0] rc;
      logic [7:0] r8;
      int         sel;
      rv  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      r8  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF :
            (sel == 2) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      rc  = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'b00110;
      cyc(($urandom_range(0, 63) != 0), rv, rv ? rc : 5'bx,
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), rv ? r8 : 8'bx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
